// File: rtl/key_stepper.sv
// Debounced single-step clock source: one strobe plus a stretched step_clk pulse per key press.
// Define KEY_STEPPER_REPEAT_EN to build the auto-repeat path (REPEAT state and repeat counting).
module key_stepper #(
  parameter int unsigned DEBOUNCE_CYC      = 500000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5000000,
  parameter int unsigned PULSE_CYC         = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic       step_clk,
  output logic       step_stb,
  output logic       held,
  output logic [7:0] step_cnt
);

  localparam int unsigned CNT_MAX_DR = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
  localparam int unsigned CNT_MAX    = (CNT_MAX_DR > REPEAT_PERIOD_CYC) ? CNT_MAX_DR : REPEAT_PERIOD_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX);
  localparam int unsigned PCNT_W     = $clog2(PULSE_CYC + 1);

  localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYC);
`ifdef KEY_STEPPER_REPEAT_EN
  localparam logic [CNT_W-1:0]  RD_LAST    = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0]  RP_LAST    = CNT_W'(REPEAT_PERIOD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DB_PRESS, S_HELD, S_REPEAT, S_DB_RELEASE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_DB_PRESS, S_HELD, S_DB_RELEASE
  } state_t;
`endif

  state_t             r_state;
  logic [1:0]         r_sync;
  logic               r_key_prev;
  logic [CNT_W-1:0]   r_cnt;
  logic [PCNT_W-1:0]  r_pcnt;
  logic               w_key_s;
  logic               w_step;

  assign w_key_s = ~r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_key_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], key_n};
      r_key_prev <= w_key_s;
    end
  end

  always_comb begin
    w_step = 1'b0;
    case (r_state)
      S_DB_PRESS: w_step = w_key_s && (r_cnt == DB_LAST);
`ifdef KEY_STEPPER_REPEAT_EN
      S_HELD:     w_step = w_key_s && (r_cnt == RD_LAST);
      S_REPEAT:   w_step = w_key_s && (r_cnt == RP_LAST);
`endif
      default:    w_step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      held    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_s) begin
            r_state <= S_DB_PRESS;
            r_cnt   <= '0;
          end
        end
        S_DB_PRESS: begin
          if (!w_key_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_step) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
            held    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!w_key_s) begin
            r_state <= S_DB_RELEASE;
            r_cnt   <= '0;
`ifdef KEY_STEPPER_REPEAT_EN
          end else if (w_step) begin
            r_state <= S_REPEAT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
`ifdef KEY_STEPPER_REPEAT_EN
        S_REPEAT: begin
          if (!w_key_s) begin
            r_state <= S_DB_RELEASE;
            r_cnt   <= '0;
          end else if (w_step) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        S_DB_RELEASE: begin
          // The first released sample after a pressed one restarts the count, matching the HELD exit.
          if (w_key_s || r_key_prev) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            held    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          held    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_stb <= 1'b0;
      step_clk <= 1'b0;
      step_cnt <= '0;
      r_pcnt   <= '0;
    end else begin
      step_stb <= w_step;
      if (w_step) begin
        step_cnt <= step_cnt + 8'd1;
        r_pcnt   <= PULSE_LOAD;
        step_clk <= 1'b1;
      end else if (r_pcnt != '0) begin
        r_pcnt   <= r_pcnt - PCNT_W'(1);
        step_clk <= (r_pcnt != PCNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_key_stepper.sv
// Directed bench for key_stepper with DEBOUNCE_CYC=8, REPEAT_DELAY_CYC=40, REPEAT_PERIOD_CYC=16, PULSE_CYC=4.
// Repeat expectations follow KEY_STEPPER_REPEAT_EN.
module tb_key_stepper;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic       step_clk;
  logic       step_stb;
  logic       held;
  logic [7:0] step_cnt;

  key_stepper #(
    .DEBOUNCE_CYC      (8),
    .REPEAT_DELAY_CYC  (40),
    .REPEAT_PERIOD_CYC (16),
    .PULSE_CYC         (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .step_clk (step_clk),
    .step_stb (step_stb),
    .held     (held),
    .step_cnt (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       key_n;
    logic       stb;
    logic       sclk;
    logic       held;
    logic [7:0] cnt;
  } vec_t;

  vec_t        vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_cnt;

  task automatic add(input int unsigned n, input logic k, input logic s, input logic c,
                     input logic h, input logic [7:0] cnt);
    vec_t v;
    v.key_n = k; v.stb = s; v.sclk = c; v.held = h; v.cnt = cnt;
    for (int unsigned i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (3) cyc();
    chk("reset_outputs", {20'd0, step_stb, step_clk, held, step_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("post_reset_outputs", {20'd0, step_stb, step_clk, held, step_cnt}, 32'd0);
  endtask

  task automatic press(output int unsigned nstb);
    nstb = 0;
    key_n = 1'b0;
    repeat (14) begin cyc(); if (step_stb) nstb++; end
    key_n = 1'b1;
    repeat (14) begin cyc(); if (step_stb) nstb++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned pos[$];
    int unsigned hi_cnt;
    int unsigned exp_rep[5];
    int unsigned exp_n;
    int unsigned nstb;
    int unsigned lat;
    logic        found;

    // Bounce: low 5, high 2, low 5, then high -> nothing happens.
    add(5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    add(5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(14, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    // Clean press held 30 cycles: step 11 after fall, held falls 11 after release.
    add(10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1,  1'b0, 1'b1, 1'b1, 1'b1, 8'd1);
    add(3,  1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
    add(16, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    add(10, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(5,  1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Release bounce: three toggles at 4-cycle spacing, held falls 11 after last rise.
    add(10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1,  1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    add(3,  1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    add(6,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    add(4,  1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    add(4,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    add(4,  1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    add(4,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    add(10, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    add(4,  1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

    rst_n = 1'b0;
    key_n = 1'b1;
    #1;
    do_reset();

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      key_n = vecs[i].key_n;
      cyc();
      n_vec++;
      if ({step_stb, step_clk, held, step_cnt} !== {vecs[i].stb, vecs[i].sclk, vecs[i].held, vecs[i].cnt}) begin
        n_err++;
        $display("FAIL vec%0d: stb/clk/held/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d", i,
                 step_stb, step_clk, held, step_cnt,
                 vecs[i].stb, vecs[i].sclk, vecs[i].held, vecs[i].cnt);
      end
    end
    exp_cnt = 8'd2;

    // Key held 100 cycles: first step at index 10, repeats at +40, +56, +72, +88.
    exp_rep = '{10, 50, 66, 82, 98};
`ifdef KEY_STEPPER_REPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    hi_cnt = 0;
    key_n = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      cyc();
      if (step_stb) pos.push_back(i);
      if (step_clk) hi_cnt++;
    end
    key_n = 1'b1;
    for (int unsigned i = 100; i < 120; i++) begin
      cyc();
      if (step_stb) pos.push_back(i);
      if (step_clk) hi_cnt++;
    end
    chk("hold_nsteps", pos.size(), exp_n);
    for (int unsigned k = 0; k < exp_n && k < pos.size(); k++)
      chk($sformatf("hold_step%0d_pos", k), pos[k], exp_rep[k]);
    chk("hold_clk_high_cycles", hi_cnt, 4 * exp_n);
    exp_cnt = exp_cnt + 8'(exp_n);
    chk("hold_step_cnt", step_cnt, exp_cnt);
    chk("hold_held_low", held, 0);

    // 256 presses from reset: counter reaches 255 then wraps to 0.
    do_reset();
    exp_cnt = 8'd0;
    for (int unsigned p = 0; p < 256; p++) begin
      press(nstb);
      exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("press%0d_nstb", p), nstb, 1);
      chk($sformatf("press%0d_cnt", p), step_cnt, exp_cnt);
      if (p == 254) chk("cnt_at_255", step_cnt, 255);
    end
    chk("cnt_wrapped_zero", step_cnt, 0);

    // Reset mid-pulse with the key still pressed.
    key_n = 1'b0;
    found = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      cyc();
      if (step_stb) begin found = 1'b1; break; end
    end
    chk("midpulse_step_seen", found, 1);
    @(posedge clk);
    #2;
    chk("midpulse_clk_high", step_clk, 1);
    rst_n = 1'b0;
    #1;
    chk("midpulse_async_clear", {20'd0, step_stb, step_clk, held, step_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nstb = 0;
    lat = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      cyc();
      if (step_stb) begin nstb++; lat = i; end
    end
    chk("after_reset_nsteps", nstb, 1);
    chk("after_reset_latency", lat, 11);
    chk("after_reset_cnt", step_cnt, 1);
    chk("after_reset_held", held, 1);
    key_n = 1'b1;
    repeat (15) cyc();
    chk("after_reset_release", held, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
